// File: rtl/ser_pkg.sv
// Shared constants for the serial line interface: register map, control
// bit positions, FSM state encodings and the baud divider derivation.
package ser_pkg;

    // Register offsets (bus address bits [3:2])
    localparam logic [1:0] REG_RCV_CTRL = 2'd0;
    localparam logic [1:0] REG_RCV_DATA = 2'd1;
    localparam logic [1:0] REG_XMT_CTRL = 2'd2;
    localparam logic [1:0] REG_XMT_DATA = 2'd3;

    // Control register bit positions
    localparam int RDY = 0;
    localparam int IEN = 1;
    localparam int OVR = 2;

    // FSM state encodings shared by receiver and transmitter
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Clocks per bit; legal range is 4..65535
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Clocks to the middle of the start bit
    function automatic int calc_half(input int clk_freq, input int baud);
        return calc_div(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/ser_if.sv
// Bus-side connection between the bus controller and the serial device.
interface ser_if;
    logic       en;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       wt;

    modport master (output en, output wr, output addr, output data_in,
                    input data_out, input wt);
    modport slave  (input en, input wr, input addr, input data_in,
                    output data_out, output wt);
endinterface

// File: rtl/ser_rcv.sv
// Receive path: rxd synchronizer, start-edge detection, 8N1 framing FSM.
// Emits a one-cycle byte_valid_o strobe with byte_o for frames with a good stop bit.
module ser_rcv
    import ser_pkg::*;
#(
    parameter int DIV  = 1302,
    parameter int HALF = 651
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o
);
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

    logic [1:0]  sync_q;
    logic        prev_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic [7:0]  byte_q, byte_d;
    logic        rx;

    assign rx           = sync_q[1];
    assign byte_valid_o = valid_q;
    assign byte_o       = byte_q;

    // Next-state logic: half-bit start qualification, then mid-bit sampling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (prev_q && !rx) begin
                    state_d = ST_START;
                    cnt_d   = HALF_M1;
                end
            end
            ST_START: begin
                if (cnt_q == 16'd0) begin
                    if (!rx) begin
                        state_d = ST_DATA;
                        cnt_d   = DIV_M1;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {rx, shift_q[7:1]};
                    cnt_d   = DIV_M1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                    if (rx) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
    end

    // State registers; synchronizer resets to the idle (high) line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            valid_q <= 1'b0;
            byte_q  <= 8'd0;
        end else begin
            sync_q  <= {sync_q[0], rxd_i};
            prev_q  <= rx;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
        end
    end

endmodule

// File: rtl/ser.sv
// UART top: register file, bus decode, transmitter FSM and the receiver instance.
module ser
    import ser_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 38400
) (
    input  logic clk,
    input  logic reset,
    ser_if.slave bus,
    output logic irq_r,
    output logic irq_t,
    input  logic rxd,
    output logic txd
);
    localparam int          DIV    = calc_div(CLK_FREQ, BAUD);
    localparam int          HALF   = calc_half(CLK_FREQ, BAUD);
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    logic        rcv_rdy_q, rcv_ien_q, rcv_ovr_q;
    logic [7:0]  rcv_hold_q;
    logic        xmt_rdy_q, xmt_ien_q;
    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_done_q, tx_done_d;
    logic        byte_valid;
    logic [7:0]  rx_byte;
    logic        rd_en, wr_en, rd_rcv_data, xmt_start;
    logic [7:0]  rd_data;

    ser_rcv #(.DIV(DIV), .HALF(HALF)) u_rcv (
        .clk          (clk),
        .reset        (reset),
        .rxd_i        (rxd),
        .byte_valid_o (byte_valid),
        .byte_o       (rx_byte)
    );

    assign rd_en       = bus.en && !bus.wr;
    assign wr_en       = bus.en && bus.wr;
    assign rd_rcv_data = rd_en && (bus.addr == REG_RCV_DATA);
    assign xmt_start   = wr_en && (bus.addr == REG_XMT_DATA) && xmt_rdy_q;

    assign bus.wt       = 1'b0;
    assign bus.data_out = rd_data;
    assign irq_r        = rcv_rdy_q && rcv_ien_q;
    assign irq_t        = xmt_rdy_q && xmt_ien_q;
    assign txd          = txd_q;

    // Read mux: selected register during a read, zero otherwise
    always_comb begin
        rd_data = 8'h00;
        if (rd_en) begin
            case (bus.addr)
                REG_RCV_CTRL: begin
                    rd_data[RDY] = rcv_rdy_q;
                    rd_data[IEN] = rcv_ien_q;
                    rd_data[OVR] = rcv_ovr_q;
                end
                REG_RCV_DATA: rd_data = rcv_hold_q;
                REG_XMT_CTRL: begin
                    rd_data[RDY] = xmt_rdy_q;
                    rd_data[IEN] = xmt_ien_q;
                end
                default: rd_data = 8'h00;
            endcase
        end
    end

    // Receive flags: an arriving byte beats a same-cycle data read, which only suppresses overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcv_rdy_q  <= 1'b0;
            rcv_ien_q  <= 1'b0;
            rcv_ovr_q  <= 1'b0;
            rcv_hold_q <= 8'h00;
        end else begin
            if (wr_en && bus.addr == REG_RCV_CTRL) rcv_ien_q <= bus.data_in[IEN];
            if (byte_valid) begin
                rcv_hold_q <= rx_byte;
                rcv_rdy_q  <= 1'b1;
                rcv_ovr_q  <= rd_rcv_data ? 1'b0 : (rcv_ovr_q || rcv_rdy_q);
            end else if (rd_rcv_data) begin
                rcv_rdy_q <= 1'b0;
                rcv_ovr_q <= 1'b0;
            end
        end
    end

    // Transmit next-state: START, 8 DATA bits LSB first, STOP, each DIV clocks
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (xmt_start) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = 3'd0;
                    tx_shift_d = bus.data_in;
                end
            end
            ST_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = DIV_M1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (tx_cnt_q == 16'd0) tx_state_d = ST_IDLE;
                else                   tx_cnt_d   = tx_cnt_q - 16'd1;
            end
        endcase
    end

    // txd is the registered line level of the current state, so it trails the FSM by one
    // clock; tx_done is delayed the same way so rdy rises exactly as the stop bit ends
    always_comb begin
        txd_d     = (tx_state_q == ST_START) ? 1'b0 :
                    (tx_state_q == ST_DATA)  ? tx_shift_q[0] : 1'b1;
        tx_done_d = (tx_state_q == ST_STOP) && (tx_cnt_q == 16'd0);
    end

    // Transmitter registers and xmt control; async reset forces the line idle at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            tx_done_q  <= 1'b0;
            xmt_rdy_q  <= 1'b1;
            xmt_ien_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_done_q  <= tx_done_d;
            if (wr_en && bus.addr == REG_XMT_CTRL) xmt_ien_q <= bus.data_in[IEN];
            if (tx_done_q)      xmt_rdy_q <= 1'b1;
            else if (xmt_start) xmt_rdy_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ser.sv
// Self-checking bench for ser with DIV = 16 (CLK_FREQ = 16 * BAUD).
`timescale 1ns/1ps
module tb_ser;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd = 1'b1;
    logic irq_r, irq_t, txd;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] rx_q[$];
    logic       tx_bits_q[$];

    ser_if bus();

    ser #(.CLK_FREQ(614400), .BAUD(38400)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq_r (irq_r),
        .irq_t (irq_t),
        .rxd   (rxd),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.en = 1'b1; bus.wr = 1'b0; bus.addr = a;
        #1 d = bus.data_out;
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.en = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.data_in = d;
        @(negedge clk);
        bus.en = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        logic bv;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            bv = (k == 0) ? 1'b0 : (k == 9) ? stop_bit : b[k-1];
            rxd = bv;
            repeat (DIV) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%02h required=%02h", name, act, exp);
        end else $display("ok   %s: %02h", name, act);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        bus.en = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0; bus.data_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({txd, irq_r, irq_t, bus.wt} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_outputs: actual txd/irq_r/irq_t/wt=%b required=1000",
                     {txd, irq_r, irq_t, bus.wt});
        end else $display("ok   reset_outputs");
        checks++;
        if (bus.data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_data_out: actual=%02h required=00", bus.data_out);
        end
        read_reg(2'd0, d); check_byte("reset_rcv_ctrl", d, 8'h00);
        read_reg(2'd2, d); check_byte("reset_xmt_ctrl", d, 8'h01);
        read_reg(2'd1, d); check_byte("reset_rcv_data", d, 8'h00);
    endtask

    task automatic test_tx();
        logic [7:0] b = 8'h55;
        logic       cur = 1'b1;
        logic       exp_txd;
        logic [7:0] exp_ctrl;
        int         wait_n = 0;
        tx_bits_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) tx_bits_q.push_back(b[k]);
        tx_bits_q.push_back(1'b1);
        write_reg(2'd3, b);
        bus.en = 1'b1; bus.wr = 1'b0; bus.addr = 2'd2;
        #1;
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("FAIL tx_not_yet: actual txd=%b required=1", txd);
        end
        while (txd !== 1'b0 && wait_n < 4) begin
            @(negedge clk); #1; wait_n++;
        end
        checks++;
        if (wait_n != 1) begin
            failures++;
            $display("FAIL tx_fall_latency: actual=%0d required=1", wait_n);
        end else $display("ok   tx_fall_latency");
        for (int i = 0; i <= 10 * DIV; i++) begin
            if (i % DIV == 0 && i < 10 * DIV) cur = tx_bits_q.pop_front();
            exp_txd  = (i < 10 * DIV) ? cur : 1'b1;
            exp_ctrl = (i == 10 * DIV) ? 8'h01 : 8'h00;
            if (i == 40) begin
                bus.wr = 1'b1; bus.addr = 2'd3; bus.data_in = 8'hFF;
            end else if (i == 41) begin
                bus.wr = 1'b0; bus.addr = 2'd2;
            end
            if (i > 0) #1;
            checks++;
            if (txd !== exp_txd) begin
                failures++;
                $display("FAIL tx_bit cycle %0d: actual=%b required=%b", i, txd, exp_txd);
            end
            if (i != 40) begin
                checks++;
                if (bus.data_out !== exp_ctrl) begin
                    failures++;
                    $display("FAIL tx_rdy cycle %0d: actual=%02h required=%02h",
                             i, bus.data_out, exp_ctrl);
                end
            end
            if (i % DIV == DIV / 2) $display("tx bit %0d txd=%b", i / DIV, txd);
            if (i < 10 * DIV) @(negedge clk);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_rx();
        logic [7:0] d;
        drive_frame(8'hA3, 1'b1);
        rx_q.push_back(8'hA3);
        read_reg(2'd0, d); check_byte("rx_ctrl_rdy", d, 8'h01);
        read_reg(2'd1, d); check_byte("rx_data", d, rx_q.pop_front());
        read_reg(2'd0, d); check_byte("rx_ctrl_clear", d, 8'h00);
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        @(negedge clk);
        rxd = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        read_reg(2'd0, d); check_byte("glitch_ctrl", d, 8'h00);
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        drive_frame(8'h11, 1'b1);
        rx_q.push_back(8'h11);
        drive_frame(8'h22, 1'b1);
        rx_q.delete();
        rx_q.push_back(8'h22);
        read_reg(2'd0, d); check_byte("ovr_ctrl", d, 8'h05);
        read_reg(2'd1, d); check_byte("ovr_data", d, rx_q.pop_front());
        read_reg(2'd0, d); check_byte("ovr_clear", d, 8'h00);
        drive_frame(8'h77, 1'b0);
        read_reg(2'd0, d); check_byte("framing_err_ctrl", d, 8'h00);
    endtask

    task automatic test_irq();
        logic [7:0] d;
        write_reg(2'd0, 8'h02);
        write_reg(2'd2, 8'h02);
        #1;
        checks++;
        if ({irq_t, irq_r} !== 2'b10) begin
            failures++;
            $display("FAIL irq_t_enable: actual irq_t/irq_r=%b required=10", {irq_t, irq_r});
        end else $display("ok   irq_t_enable");
        drive_frame(8'h5A, 1'b1);
        rx_q.push_back(8'h5A);
        #1;
        checks++;
        if (irq_r !== 1'b1) begin
            failures++;
            $display("FAIL irq_r_set: actual=%b required=1", irq_r);
        end else $display("ok   irq_r_set");
        read_reg(2'd0, d); check_byte("irq_rcv_ctrl", d, 8'h03);
        read_reg(2'd1, d); check_byte("irq_rcv_data", d, rx_q.pop_front());
        #1;
        checks++;
        if (irq_r !== 1'b0) begin
            failures++;
            $display("FAIL irq_r_clear: actual=%b required=0", irq_r);
        end else $display("ok   irq_r_clear");
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        write_reg(2'd3, 8'h3C);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (txd !== 1'b0) begin
            failures++;
            $display("FAIL midtx_txd: actual=%b required=0", txd);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({txd, irq_t} !== 2'b10) begin
            failures++;
            $display("FAIL async_reset: actual txd/irq_t=%b required=10", {txd, irq_t});
        end else $display("ok   async_reset");
        @(negedge clk);
        reset = 1'b0;
        read_reg(2'd2, d); check_byte("post_reset_xmt_ctrl", d, 8'h01);
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_glitch();
        test_overrun();
        test_irq();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ser.md
# ser

Serial line interface (UART) occupying one of the two serial slots in I/O space, 8N1 framing at a fixed baud rate. Sits directly downstream of the bus controller. It consumes that controller's per-device enable, write, register address and byte data, and returns read data and a wait signal. It drives the external TxD line, samples RxD, and raises separate receive and transmit interrupt requests toward the CPU.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD, 38400, line rate; DIV = CLK_FREQ/BAUD (integer division, 1302 at defaults); legal DIV range 4..65535
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  device selected by bus controller this cycle
- wr  in  1  1 = write, 0 = read (valid when en=1)
- addr  in  2 ([3:2])  register select: 0 rcv ctrl, 1 rcv data, 2 xmt ctrl, 3 xmt data
- data_in  in  8  write data
- data_out  out  8  read data
- wt  out  1  wait request to bus controller
- irq_r  out  1  receive interrupt request
- irq_t  out  1  transmit interrupt request
- rxd  in  1  serial input, asynchronous to clk
- txd  out  1  serial output, idle high

## Operation
- Rcv ctrl read: bit0 = rdy, bit1 = ien, bit2 = ovr, bits 7:3 = 0.
- Rcv ctrl write: only bit1 (ien) is stored.
- Rcv data read: returns the holding byte; clears rdy and ovr on that clock edge.
- Rcv data write: ignored.
- Xmt ctrl read: bit0 = rdy, bit1 = ien. Write stores ien only.
- Xmt data write with rdy=1: latches the byte, clears rdy, starts a frame. Write with rdy=0 is ignored. Read returns 0.
- data_out = selected register when en=1 and wr=0, otherwise 0x00.
- wt = 0 always; every access completes in one cycle.
- irq_r = rcv rdy & rcv ien; irq_t = xmt rdy & xmt ien; both combinational from registers.
- Receiver states:
  - IDLE: wait for a falling edge on synchronized rxd.
  - START: count DIV/2; if rxd still 0 go to DATA, else return to IDLE (glitch rejected).
  - DATA: 8 samples at DIV intervals, LSB first.
  - STOP: sample once after DIV.
    - Stop = 1: byte goes to holding register, rdy set; if rdy was already 1, ovr set and old byte overwritten.
    - Stop = 0 (framing error): byte discarded, flags unchanged.
  - Then return to IDLE.
- Transmitter states:
  - IDLE: txd = 1.
  - START: txd = 0 for DIV cycles.
  - DATA: 8 bits LSB first, DIV cycles each.
  - STOP: txd = 1 for DIV cycles.
  - Then set rdy and return to IDLE.

## Timing
- Reset values:
  - txd = 1, data_out = 0, wt = 0, irq_r = 0, irq_t = 0.
  - rcv rdy/ien/ovr = 0; xmt rdy = 1, xmt ien = 0.
  - Both state machines in IDLE, counters 0.
- Reset asserted mid-frame: txd returns to 1 immediately (asynchronous) and the frame is abandoned. The holding byte is don't-care.
- rxd passes through a 2-flop synchronizer. Start-edge detection latency is 2–3 clocks, absorbed into the half-bit count.
- TxD falls on the first clock edge after the accepting write edge.
- Xmt rdy rises exactly 10*DIV cycles after TxD falls, at the end of the stop bit.
- Simultaneous frame completion and rcv data read in the same cycle:
  - The new byte wins: rdy stays 1, ovr stays 0.
  - The read returns the old byte.
- Simultaneous xmt rdy set and xmt data write: the write is ignored (rdy was 0 when sampled).
- Bit counters are 16-bit and count down from DIV-1 to 0; the bit index is 3-bit and wraps after 7.

## Structure
- Shared package/include ser_defs holds:
  - register offsets (0..3)
  - control bit positions (RDY = 0, IEN = 1, OVR = 2)
  - the DIV and DIV/2 derivation from CLK_FREQ and BAUD
- One sub-module is natural: ser_rcv. It contains the synchronizer, receive state machine and shift register, and outputs a one-cycle byte_valid strobe plus the 8-bit byte.
- Register file, transmitter and bus logic remain in ser.

## Test plan
- Reset, then read addr 0,2,1 -> 0x00, 0x01, 0x00; txd = 1; irq_r = irq_t = 0.
- Write 0x55 to addr 3 (DIV = 16 override):
  - txd sequence 0,1,0,1,0,1,0,1,0,1, 16 cycles each.
  - addr 2 reads 0x00 during the frame and 0x01 exactly 160 cycles after txd falls.
  - A second write of 0xFF mid-frame is ignored.
- Drive an rxd frame of 0xA3 with correct stop bit:
  - addr 0 reads 0x01, addr 1 reads 0xA3.
  - A following read of addr 0 -> 0x00.
- Glitch rxd low for DIV/4 cycles -> no state change; addr 0 stays 0x00.
- Two frames 0x11, 0x22 without a read:
  - addr 0 -> 0x05, addr 1 -> 0x22, then addr 0 -> 0x00.
  - A frame with stop bit 0 -> addr 0 unchanged.
- Interrupts:
  - Write 0x02 to addr 0 and addr 2 -> irq_t = 1 at once; irq_r = 1 after the next received frame, cleared by the addr 1 read.
  - Assert reset mid-transmit -> txd = 1 same cycle, irq_t = 0.
